// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a DEPTH-entry instruction buffer and redirect flushing.
// Ports:
//   clk_in, rst_n_in            rising-edge clock, asynchronous active-low reset
//   imem_req_out/addr_out       request to instruction memory, held until imem_gnt_in
//   imem_gnt_in                 request accepted this cycle
//   imem_rvalid_in/rdata_in     in-order response from instruction memory
//   redirect_in/redirect_pc_in  branch/jump redirect and its target
//   stall_in                    decode not ready
//   instr_out/pc_out/valid_out  instruction presented to decode
// Optional feature: define FETCH_BYPASS_EN to present a response in the cycle it arrives when the buffer is empty.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    output logic             imem_req_out,
    output logic [WIDTH-1:0] imem_addr_out,
    input  logic             imem_gnt_in,
    input  logic             imem_rvalid_in,
    input  logic [WIDTH-1:0] imem_rdata_in,
    input  logic             redirect_in,
    input  logic [WIDTH-1:0] redirect_pc_in,
    input  logic             stall_in,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             valid_out
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt, resp_pc;
    logic [WIDTH-1:0] fifo_instr [DEPTH];
    logic [WIDTH-1:0] fifo_pc    [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, outstanding, outstanding_nxt, discard, discard_nxt;
    logic [CW-1:0]    disc_base, disc_left;
    logic             in_fetch, fire, push, pop, bypass, dropping;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_fetch      = state == FETCH;
        // credit uses registered counts only, so a pop this cycle frees nothing until next cycle
        imem_req_out  = rst_n_in && in_fetch && (int'(outstanding) + int'(count) < DEPTH);
        imem_addr_out = pc;
        fire          = imem_req_out && imem_gnt_in;
        // responses are in order and pc advanced by 4 per grant, so the oldest in-flight address is behind pc
        resp_pc       = pc - (WIDTH'(outstanding) << 2);
`ifdef FETCH_BYPASS_EN
        bypass        = rst_n_in && in_fetch && count == '0 && imem_rvalid_in && !redirect_in;
`else
        bypass        = 1'b0;
`endif
        valid_out     = rst_n_in && in_fetch && (count != '0 || bypass);
        instr_out     = bypass ? imem_rdata_in : (valid_out ? fifo_instr[rd_ptr] : '0);
        pc_out        = bypass ? resp_pc : (valid_out ? fifo_pc[rd_ptr] : '0);
        pop           = valid_out && !stall_in && !bypass;
        push          = in_fetch && imem_rvalid_in && !redirect_in && !(bypass && !stall_in);
        // the same arithmetic tracks live requests in FETCH and stale ones while discarding
        disc_base     = in_fetch ? outstanding : discard;
        disc_left     = disc_base + CW'(fire) - CW'(imem_rvalid_in);
        dropping      = redirect_in || !in_fetch;
        outstanding_nxt = dropping ? '0 : disc_left;
        discard_nxt     = dropping ? disc_left : '0;
        state_nxt       = dropping && disc_left != '0 ? FLUSH : FETCH;
        pc_nxt          = redirect_in ? (redirect_pc_in & ~WIDTH'(3)) : (fire ? pc + WIDTH'(4) : pc);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata_in;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized check of fetch_unit against a transaction-level program-order model.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, stall = 1'b0, valid;
    logic [31:0] addr, rdata = '0, redirect_pc = '0, instr, pc;

    fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .imem_req_out(req), .imem_addr_out(addr), .imem_gnt_in(gnt),
        .imem_rvalid_in(rvalid), .imem_rdata_in(rdata),
        .redirect_in(redirect), .redirect_pc_in(redirect_pc), .stall_in(stall),
        .instr_out(instr), .pc_out(pc), .valid_out(valid)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] mem_q[$], live_q[$], exp_q[$];
    int          stale;
    logic [31:0] pc_m;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        live_q.delete();
        exp_q.delete();
        stale = 0;
        pc_m  = RESET_PC;
    endtask

    initial begin
        logic        exp_req, exp_valid, was_empty, byp;
        logic [31:0] exp_pc, a;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst_n       = 1'b1;
            gnt         = $urandom_range(0, 3) != 0;
            rvalid      = mem_q.size() > 0 && $urandom_range(0, 2) != 0;
            rdata       = rvalid ? word(mem_q[0]) : $urandom;
            redirect    = cyc > 5 && $urandom_range(0, 15) == 0;
            redirect_pc = $urandom_range(0, 1) != 0 ? 32'h103 : $urandom;
            stall       = (cyc % 40 >= 30) || $urandom_range(0, 3) == 0;
            #1;
            exp_req   = stale == 0 && live_q.size() + exp_q.size() < DEPTH;
            was_empty = exp_q.size() == 0;
            byp       = BYP && stale == 0 && rvalid && !redirect && was_empty && live_q.size() > 0;
            exp_valid = !was_empty || byp;
            chk("req", {31'b0, req}, {31'b0, exp_req});
            if (exp_req) chk("addr", addr, pc_m);
            chk("valid", {31'b0, valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                exp_pc = byp ? live_q[0] : exp_q[0];
                chk("pc_out", pc, exp_pc);
                chk("instr", instr, word(exp_pc));
            end
            if (rvalid) void'(mem_q.pop_front());
            if (req && gnt) mem_q.push_back(addr);
            if (!was_empty && !stall && !redirect) void'(exp_q.pop_front());
            if (rvalid) begin
                if (stale > 0) stale--;
                else if (live_q.size() > 0) begin
                    a = live_q.pop_front();
                    if (!redirect && !(byp && !stall)) exp_q.push_back(a);
                end
            end
            if (exp_req && gnt) begin
                live_q.push_back(pc_m);
                pc_m += 32'd4;
            end
            if (redirect) begin
                stale += live_q.size();
                live_q.delete();
                exp_q.delete();
                pc_m = redirect_pc & ~32'h3;
            end
            if (cyc == 250 || cyc == 520) begin
                #2 rst_n = 1'b0;
                #1;
                chk("arst_req", {31'b0, req}, 32'h0);
                chk("arst_valid", {31'b0, valid}, 32'h0);
                chk("arst_instr", instr, 32'h0);
                chk("arst_pc", pc, 32'h0);
                model_reset();
                gnt      = 1'b0;
                rvalid   = 1'b0;
                redirect = 1'b0;
            end
            @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
